// File: rtl/hamming_st_pkg.sv
// Shared types for the Hamming-pipeline Avalon-ST blocks.
package hamming_st_pkg;

    // Arbiter lock state, one-hot so each state is a single flop bit.
    typedef enum logic [1:0] {
        IDLE   = 2'b01,
        LOCKED = 2'b10
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: returns the first set request at or after
// (last_grant + 1) mod N, wrapping around. Purely combinational.
module rr_priority_picker #(
    parameter int N       = 3,
    parameter int GRANT_W = 2
) (
    input  logic [N-1:0]       req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic               found,
    output logic [GRANT_W-1:0] winner
);

    // Modular upward scan; the first hit after last_grant wins.
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last_grant) + k) % N;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = GRANT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/avalon_st_packet_arbiter.sv
// Packet-aware round-robin arbiter merging N_IN Avalon-ST streams into one
// registered output stream. A grant is taken on SOP and held until EOP.
module avalon_st_packet_arbiter
    import hamming_st_pkg::*;
#(
    parameter  int N_IN    = 3,
    parameter  int WIDTH   = 11,
    localparam int GRANT_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_startofpacket,
    input  logic [N_IN-1:0]       in_endofpacket,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_startofpacket,
    output logic                  out_endofpacket,
    output logic [GRANT_W-1:0]    grant,
    output logic                  busy,
    output logic                  orphan_drop
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sop;
        logic             eop;
    } st_beat_t;

    arb_state_t         state;
    logic [GRANT_W-1:0] last_grant;
    st_beat_t           out_beat;
    st_beat_t           port_beat [N_IN];
    st_beat_t           sel_beat;
    logic               out_stall;
    logic               accept;
    logic               orphan_any;
    logic               pick_found;
    logic [GRANT_W-1:0] pick_winner;

    assign out_data          = out_beat.data;
    assign out_startofpacket = out_beat.sop;
    assign out_endofpacket   = out_beat.eop;

    assign out_stall  = out_valid && !out_ready;
    assign orphan_any = |(in_valid & ~in_startofpacket);

    rr_priority_picker #(
        .N       (N_IN),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .req        (in_valid & in_startofpacket),
        .last_grant (last_grant),
        .found      (pick_found),
        .winner     (pick_winner)
    );

    // Unpack the flat input bus into per-port beats and select the granted one.
    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            port_beat[i].data = in_data[i*WIDTH +: WIDTH];
            port_beat[i].sop  = in_startofpacket[i];
            port_beat[i].eop  = in_endofpacket[i];
        end
        sel_beat = port_beat[grant];
    end

    // Ready: only the locked port while locked, otherwise only orphan beats.
    always_comb begin
        in_ready = '0;
        accept   = 1'b0;
        if (state == LOCKED) begin
            in_ready[grant] = !out_stall;
            accept          = in_valid[grant] && !out_stall;
        end else begin
            in_ready = in_valid & ~in_startofpacket;
        end
    end

    // Lock FSM plus the one-beat output register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            last_grant  <= GRANT_W'(N_IN - 1);
            out_valid   <= 1'b0;
            out_beat    <= '0;
            orphan_drop <= 1'b0;
        end else begin
            orphan_drop <= (state == IDLE) && orphan_any;

            if (accept) begin
                out_beat  <= sel_beat;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        state <= LOCKED;
                        grant <= pick_winner;
                        busy  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (accept && sel_beat.eop) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        last_grant <= grant;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// Directed bench for avalon_st_packet_arbiter (N_IN=3, WIDTH=11).
module tb_avalon_st_packet_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  in_valid, in_ready, in_sop, in_eop;
    logic [32:0] in_data;
    logic        out_ready, out_valid, out_sop, out_eop;
    logic [10:0] out_data;
    logic [1:0]  grant;
    logic        busy, orphan_drop;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int orph_cnt = 0;

    logic [2:0]  hs    = '0;
    logic        oxfer = 1'b0;
    logic [12:0] src_q [3][$];
    logic [12:0] out_log [$];
    int          out_cyc [$];

    avalon_st_packet_arbiter #(
        .N_IN  (3),
        .WIDTH (11)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .grant             (grant),
        .busy              (busy),
        .orphan_drop       (orphan_drop)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] bt(input logic [10:0] d, input logic s, input logic e);
        return {d, s, e};
    endfunction

    // Present the head of each source queue; out_ready as given.
    task automatic drive(input logic ordy);
        logic [12:0] b;
        out_ready = ordy;
        for (int i = 0; i < 3; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                in_valid[i]            = 1'b1;
                in_data[i*11 +: 11]    = b[12:2];
                in_sop[i]              = b[1];
                in_eop[i]              = b[0];
            end else begin
                in_valid[i]            = 1'b0;
                in_data[i*11 +: 11]    = '0;
                in_sop[i]              = 1'b0;
                in_eop[i]              = 1'b0;
            end
        end
    endtask

    // One clock: retire handshakes seen before the edge, drive, then sample.
    task automatic tick(input logic ordy);
        @(posedge clock);
        @(negedge clock);
        cyc++;
        for (int i = 0; i < 3; i++)
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive(ordy);
        #1;
        hs    = in_valid & in_ready;
        oxfer = out_valid & out_ready;
        if (oxfer) begin
            out_log.push_back({out_data, out_sop, out_eop});
            out_cyc.push_back(cyc);
        end
        if (orphan_drop) orph_cnt++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) src_q[i].delete();
        hs    = '0;
        oxfer = 1'b0;
        drive(1'b1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        out_log.delete();
        out_cyc.delete();
        orph_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        drive(1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_beat", {out_data, out_sop, out_eop}, 0);
        check("rst_busy_grant", {busy, grant, orphan_drop}, 0);
        check("rst_in_ready", 32'(in_ready), 0);
        do_reset();

        // Test 1: three-beat packet on port 0.
        src_q[0].push_back(bt(11'h001, 1, 0));
        src_q[0].push_back(bt(11'h002, 0, 0));
        src_q[0].push_back(bt(11'h003, 0, 1));
        tick(1);
        check("t1_c0_valid", 32'(out_valid), 0);
        tick(1);
        check("t1_c1_lock", {busy, grant, out_valid}, {1'b1, 2'd0, 1'b0});
        tick(1);
        check("t1_beat0", {out_valid, out_data, out_sop, out_eop}, {1'b1, 11'h001, 1'b1, 1'b0});
        tick(1);
        check("t1_beat1", {out_valid, out_data, out_sop, out_eop}, {1'b1, 11'h002, 1'b0, 1'b0});
        tick(1);
        check("t1_beat2", {out_valid, out_data, out_sop, out_eop}, {1'b1, 11'h003, 1'b0, 1'b1});
        check("t1_busy_drop", 32'(busy), 0);
        tick(1);
        check("t1_idle_valid", 32'(out_valid), 0);

        // Test 2: two rounds of 2-beat packets on all ports -> 0,1,2,0,1,2.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 3; p++)
                for (int b = 0; b < 2; b++)
                    src_q[p].push_back(bt(11'(16'h100 + p*16 + r*2 + b), b == 0, b == 1));
        repeat (24) tick(1);
        check("t2_count", out_log.size(), 12);
        begin
            logic [12:0] exp2 [12];
            exp2 = '{bt(11'h100,1,0), bt(11'h101,0,1), bt(11'h110,1,0), bt(11'h111,0,1),
                     bt(11'h120,1,0), bt(11'h121,0,1), bt(11'h102,1,0), bt(11'h103,0,1),
                     bt(11'h112,1,0), bt(11'h113,0,1), bt(11'h122,1,0), bt(11'h123,0,1)};
            for (int k = 0; k < 12 && k < out_log.size(); k++)
                check($sformatf("t2_beat%0d", k), 32'(out_log[k]), 32'(exp2[k]));
        end
        if (out_cyc.size() == 12)
            for (int k = 1; k < 6; k++) begin
                check($sformatf("t2_gap%0d", k), 32'(out_cyc[2*k] - out_cyc[2*k-1]), 2);
                check($sformatf("t2_inpkt%0d", k), 32'(out_cyc[2*k+1] - out_cyc[2*k]), 1);
            end

        // Test 3: stall in the middle of a port-1 packet.
        out_log.delete();
        src_q[1].push_back(bt(11'h200, 1, 0));
        src_q[1].push_back(bt(11'h201, 0, 0));
        src_q[1].push_back(bt(11'h202, 0, 1));
        for (int w = 0; w < 10 && !out_valid; w++) tick(1);
        check("t3_first", {out_valid, out_data}, {1'b1, 11'h200});
        tick(0);
        check("t3_stall1", {out_valid, out_data, in_ready[1]}, {1'b1, 11'h201, 1'b0});
        tick(0);
        check("t3_stall2", {out_valid, out_data, in_ready[1]}, {1'b1, 11'h201, 1'b0});
        tick(1);
        check("t3_resume", {out_valid, out_data, in_ready[1]}, {1'b1, 11'h201, 1'b1});
        tick(1);
        check("t3_last", {out_valid, out_data, out_eop}, {1'b1, 11'h202, 1'b1});
        tick(1);
        check("t3_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check("t3_log0", 32'(out_log[0]), 32'(bt(11'h200, 1, 0)));
            check("t3_log1", 32'(out_log[1]), 32'(bt(11'h201, 0, 0)));
            check("t3_log2", 32'(out_log[2]), 32'(bt(11'h202, 0, 1)));
        end

        // Test 4: orphan beat on port 2 while idle.
        out_log.delete();
        orph_cnt = 0;
        src_q[2].push_back(bt(11'h055, 0, 0));
        tick(1);
        check("t4_in_ready", 32'(in_ready), 32'(3'b100));
        repeat (3) tick(1);
        check("t4_orphan_pulses", orph_cnt, 1);
        check("t4_no_output", out_log.size(), 0);
        check("t4_not_busy", 32'(busy), 0);

        // Test 5: single-beat packet on port 1, port 0 SOP pending behind it.
        do_reset();
        src_q[1].push_back(bt(11'h3FF, 1, 1));
        tick(1);
        src_q[0].push_back(bt(11'h0A0, 1, 0));
        src_q[0].push_back(bt(11'h0A1, 0, 1));
        repeat (8) tick(1);
        check("t5_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check("t5_single", 32'(out_log[0]), 32'(bt(11'h3FF, 1, 1)));
            check("t5_p0_sop", 32'(out_log[1]), 32'(bt(11'h0A0, 1, 0)));
            check("t5_p0_eop", 32'(out_log[2]), 32'(bt(11'h0A1, 0, 1)));
        end

        // Test 6: reset mid-packet, then port 0 wins first arbitration.
        do_reset();
        src_q[0].push_back(bt(11'h0B0, 1, 0));
        src_q[0].push_back(bt(11'h0B1, 0, 0));
        src_q[0].push_back(bt(11'h0B2, 0, 0));
        src_q[0].push_back(bt(11'h0B3, 0, 1));
        for (int w = 0; w < 10 && !out_valid; w++) tick(1);
        tick(1);
        check("t6_midpkt", {busy, out_valid, out_data}, {1'b1, 1'b1, 11'h0B1});
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_valid", {out_valid, out_data, out_sop, out_eop}, 0);
        check("t6_async_state", {busy, grant, orphan_drop}, 0);
        do_reset();
        src_q[2].push_back(bt(11'h0C0, 1, 1));
        src_q[0].push_back(bt(11'h0D0, 1, 1));
        tick(1);
        tick(1);
        check("t6_first_grant", {busy, grant}, {1'b1, 2'd0});
        repeat (6) tick(1);
        check("t6_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check("t6_first_pkt", 32'(out_log[0]), 32'(bt(11'h0D0, 1, 1)));
            check("t6_second_pkt", 32'(out_log[1]), 32'(bt(11'h0C0, 1, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
